// File: rtl/dmem_pkg.sv
// Shared widths, size/state encodings and lane helpers for the banked data memory.
// Optional feature macro: DMEM_SEXT_EN (sign-extension of sub-word loads).
package dmem_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(LANES);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned MASK_W = 2 * LANES;
    localparam int unsigned WIDE_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Size code 3 is illegal and behaves as a full word.
    function automatic int unsigned size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            default: return LANES;
        endcase
    endfunction

    // Byte-enable mask over two consecutive words; upper half set means misaligned.
    function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
        logic [MASK_W-1:0] base;
        base = MASK_W'((32'd1 << size_bytes(size)) - 32'd1);
        return base << off;
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] data,
                                                 input logic [1:0]        size,
                                                 input logic              sext);
        logic [DATA_W-1:0] res;
        case (size)
            SZ_BYTE: res = {{(DATA_W-8){sext & data[7]}}, data[7:0]};
            SZ_HALF: res = {{(DATA_W-16){sext & data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction
endpackage

// File: rtl/dmem_lane_bank.sv
// One byte-wide bank: a read/write port and a read-only port, both with
// registered read data that returns the contents from before a same-cycle write.
module dmem_lane_bank
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rw_en_i,
    input  logic             rw_we_i,
    input  logic [IDX_W-1:0] rw_idx_i,
    input  logic [7:0]       rw_wdata_i,
    output logic [7:0]       rw_rdata_o,
    input  logic             r_en_i,
    input  logic [IDX_W-1:0] r_idx_i,
    output logic [7:0]       r_rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rw_rdata_q;
    logic [7:0] r_rdata_q;

    // Storage array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (rw_en_i && rw_we_i) begin
            mem_q[rw_idx_i] <= rw_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_rdata_q <= 8'd0;
            r_rdata_q  <= 8'd0;
        end else begin
            if (rw_en_i) rw_rdata_q <= mem_q[rw_idx_i];
            if (r_en_i)  r_rdata_q  <= mem_q[r_idx_i];
        end
    end

    assign rw_rdata_o = rw_rdata_q;
    assign r_rdata_o  = r_rdata_q;
endmodule

// File: rtl/dmem_banked.sv
// Byte-laned data memory: P0 read/write with misaligned split, P1 aligned word read.
// Build option DMEM_SEXT_EN enables sign extension of sub-word P0 loads.
module dmem_banked
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_sext,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_en,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata
);
    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              p1_rvalid_q;
    logic              resp_we_q, resp_we_d;
    logic              resp_mis_q, resp_mis_d;
    logic              resp_sext_q, resp_sext_d;
    logic [1:0]        resp_size_q, resp_size_d;
    logic [OFF_W-1:0]  resp_off_q, resp_off_d;
    logic [IDX_W-1:0]  hi_idx_q, hi_idx_d;
    logic [LANES-1:0]  hi_mask_q, hi_mask_d;
    logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              accept;
    logic              sext_en;
    logic [OFF_W-1:0]  in_off;
    logic [IDX_W-1:0]  in_idx;
    logic [MASK_W-1:0] in_mask;
    logic              in_mis;
    logic [WIDE_W-1:0] in_wide;
    logic              bank_en, bank_we;
    logic [IDX_W-1:0]  bank_idx;
    logic [LANES-1:0]  bank_mask;
    logic [DATA_W-1:0] bank_wdata, bank_rdata, p1_word;
    logic [IDX_W-1:0]  p1_idx;
    logic [WIDE_W-1:0] rd_wide;
    logic [DATA_W-1:0] rd_word;
    logic              unused_addr;

`ifdef DMEM_SEXT_EN
    assign sext_en = p0_sext;
`else
    logic unused_sext;
    assign sext_en     = 1'b0;
    assign unused_sext = p0_sext;
`endif

    assign unused_addr = ^{p0_addr[ADDR_W-1:OFF_W+IDX_W], p1_addr[ADDR_W-1:OFF_W+IDX_W],
                           p1_addr[OFF_W-1:0]};

    assign accept  = p0_valid && ready_q;
    assign in_off  = p0_addr[OFF_W-1:0];
    assign in_idx  = p0_addr[OFF_W+IDX_W-1:OFF_W];
    assign in_mask = lane_mask(p0_size, in_off);
    assign in_mis  = |in_mask[MASK_W-1:LANES];
    assign in_wide = WIDE_W'(p0_wdata) << {in_off, 3'b000};
    assign p1_idx  = p1_addr[OFF_W+IDX_W-1:OFF_W];

    // Next-state, bank port steering and request latching.
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        rvalid_d    = 1'b0;
        resp_we_d   = resp_we_q;
        resp_mis_d  = resp_mis_q;
        resp_sext_d = resp_sext_q;
        resp_size_d = resp_size_q;
        resp_off_d  = resp_off_q;
        hi_idx_d    = hi_idx_q;
        hi_mask_d   = hi_mask_q;
        hi_wdata_d  = hi_wdata_q;
        lo_d        = lo_q;
        bank_en     = 1'b0;
        bank_we     = 1'b0;
        bank_idx    = in_idx;
        bank_mask   = '0;
        bank_wdata  = in_wide[DATA_W-1:0];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bank_en     = 1'b1;
                    bank_we     = p0_we;
                    bank_mask   = in_mask[LANES-1:0];
                    resp_we_d   = p0_we;
                    resp_mis_d  = in_mis;
                    resp_sext_d = sext_en;
                    resp_size_d = p0_size;
                    resp_off_d  = in_off;
                    if (in_mis) begin
                        state_d    = SPLIT;
                        ready_d    = 1'b0;
                        hi_idx_d   = in_idx + IDX_W'(1);
                        hi_mask_d  = in_mask[MASK_W-1:LANES];
                        hi_wdata_d = in_wide[WIDE_W-1:DATA_W];
                    end else begin
                        rvalid_d = 1'b1;
                    end
                end
            end
            SPLIT: begin
                // Second word of a misaligned access; keep the first word's read data.
                bank_en    = 1'b1;
                bank_we    = resp_we_q;
                bank_idx   = hi_idx_q;
                bank_mask  = hi_mask_q;
                bank_wdata = hi_wdata_q;
                lo_d       = bank_rdata;
                rvalid_d   = 1'b1;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            p1_rvalid_q <= 1'b0;
            resp_we_q   <= 1'b0;
            resp_mis_q  <= 1'b0;
            resp_sext_q <= 1'b0;
            resp_size_q <= 2'd0;
            resp_off_q  <= '0;
            hi_idx_q    <= '0;
            hi_mask_q   <= '0;
            hi_wdata_q  <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            p1_rvalid_q <= p1_en;
            resp_we_q   <= resp_we_d;
            resp_mis_q  <= resp_mis_d;
            resp_sext_q <= resp_sext_d;
            resp_size_q <= resp_size_d;
            resp_off_q  <= resp_off_d;
            hi_idx_q    <= hi_idx_d;
            hi_mask_q   <= hi_mask_d;
            hi_wdata_q  <= hi_wdata_d;
            lo_q        <= lo_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dmem_lane_bank u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .rw_en_i    (bank_en),
            .rw_we_i    (bank_we & bank_mask[l]),
            .rw_idx_i   (bank_idx),
            .rw_wdata_i (bank_wdata[8*l +: 8]),
            .rw_rdata_o (bank_rdata[8*l +: 8]),
            .r_en_i     (p1_en),
            .r_idx_i    (p1_idx),
            .r_rdata_o  (p1_word[8*l +: 8])
        );
    end

    // Realign the one or two fetched words down to the requested byte.
    assign rd_wide = resp_mis_q ? {bank_rdata, lo_q} : {{DATA_W{1'b0}}, bank_rdata};
    assign rd_word = DATA_W'(rd_wide >> {resp_off_q, 3'b000});

    assign p0_ready  = ready_q;
    assign p0_rvalid = rvalid_q;
    assign p0_rdata  = (rvalid_q && !resp_we_q) ? extend(rd_word, resp_size_q, resp_sext_q)
                                                : '0;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_rdata  = p1_word;
endmodule

// File: tb/tb_dmem_banked.sv
// Scoreboard bench for dmem_banked: byte-array reference model, directed cases, random traffic.
module tb_dmem_banked;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned NBYTES = 4 * DEPTH;
`ifdef DMEM_SEXT_EN
    localparam bit SEXT_ON = 1'b1;
`else
    localparam bit SEXT_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int unsigned b;
        logic [7:0]  v;
    } pw_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_we, p0_sext, p1_en;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr;
    logic        p0_ready, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;

    dmem_banked dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_size   (p0_size),
        .p0_sext   (p0_sext),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_en     (p1_en),
        .p1_addr   (p1_addr),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [NBYTES];
    pw_t        pend[$];
    exp_t       q0[$];
    exp_t       q1[$];
    bit         exp_ready = 1'b1;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned byte_at(input logic [31:0] a, input int unsigned k);
        logic [31:0] s;
        s = a + 32'(k);
        return s % NBYTES;
    endfunction

    function automatic int unsigned nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input bit sx);
        int unsigned n;
        logic [31:0] v;
        n = nb(sz);
        v = 32'd0;
        for (int k = 0; k < int'(n); k++) v[8*k +: 8] = mem[byte_at(a, k)];
        if (SEXT_ON && sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    // Drives one cycle of stimulus (called at a falling edge) and updates the model.
    task automatic step(input bit v, input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit pe, input logic [31:0] pa,
                        input bit use_c, input logic [31:0] c, output bit acc);
        exp_t        e;
        int unsigned n, off, w;
        bit          mis;
        p0_valid = v; p0_we = we; p0_size = sz; p0_sext = sx; p0_addr = a; p0_wdata = wd;
        p1_en = pe; p1_addr = pa;
        chk("p0_ready", 32'(p0_ready), 32'(exp_ready));
        if (pe) begin
            w = (pa >> 2) % DEPTH;
            e.data = {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
            e.due  = cyc + 1;
            q1.push_back(e);
        end
        foreach (pend[i]) mem[pend[i].b] = pend[i].v;
        pend.delete();
        acc = v && exp_ready;
        exp_ready = 1'b1;
        if (acc) begin
            n   = nb(sz);
            off = a % 4;
            mis = (off + n) > 4;
            e.data = use_c ? c : (we ? 32'd0 : model_load(a, sz, sx));
            e.due  = cyc + (mis ? 2 : 1);
            q0.push_back(e);
            if (we) begin
                for (int k = 0; k < int'(n); k++) begin
                    if (off + k >= 4) pend.push_back('{byte_at(a, k), wd[8*k +: 8]});
                    else              mem[byte_at(a, k)] = wd[8*k +: 8];
                end
            end
            exp_ready = !mis;
        end
        @(negedge clk);
    endtask

    task automatic p0_op(input bit we, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input bit use_c, input logic [31:0] c);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) step(1'b1, we, sz, sx, a, wd, 1'b0, 32'd0, use_c, c, acc);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL p0_accept: request at %h never taken", a);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, acc);
    endtask

    function automatic int unsigned win(input int unsigned i);
        return (i < 17) ? i : DEPTH - 21 + i;
    endfunction

    // Response monitor: pops expectations whenever either port reports data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p0_rvalid === 1'b1) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL p0_rvalid: unexpected pulse at cycle %0d", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("p0_rdata", p0_rdata, e.data);
                    chk("p0_latency", 32'(cyc), 32'(e.due));
                end
            end else if (q0.size() != 0 && q0[0].due < cyc) begin
                e = q0.pop_front();
                total++; bad++;
                $display("FAIL p0_rvalid: missing, due %0d now %0d", e.due, cyc);
            end
            if (p1_rvalid === 1'b1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL p1_rvalid: unexpected pulse at cycle %0d", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("p1_rdata", p1_rdata, e.data);
                    chk("p1_latency", 32'(cyc), 32'(e.due));
                end
            end else if (q1.size() != 0 && q1[0].due < cyc) begin
                e = q1.pop_front();
                total++; bad++;
                $display("FAIL p1_rvalid: missing, due %0d now %0d", e.due, cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc, have, rv, rwe, rsx, pe;
        logic [1:0]  rsz;
        logic [31:0] ra, rwd, pa;
        int unsigned i0;
        exp_t        e;

        for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'd0;
        rst_n = 1'b0; p0_valid = 1'b0; p0_we = 1'b0; p0_size = 2'd0; p0_sext = 1'b0;
        p0_addr = 32'd0; p0_wdata = 32'd0; p1_en = 1'b0; p1_addr = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_p0_ready", 32'(p0_ready), 32'd1);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Prefill the working window so every later read has a defined value.
        for (int unsigned i = 0; i < 21; i++) p0_op(1'b1, 2'd2, 1'b0, win(i) * 4, $urandom(), 1'b0, 32'd0);
        idle(2);

        p0_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        p0_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF);

        p0_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b0, 32'd0);
        p0_op(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1, SEXT_ON ? 32'hFFFFFF80 : 32'h00000080);
        p0_op(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b1, 32'h00000080);

        p0_op(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, 1'b0, 32'd0);
        p0_op(1'b0, 2'd2, 1'b0, 32'h0E, 32'd0, 1'b1, 32'h11223344);
        p0_op(1'b0, 2'd1, 1'b0, 32'h0E, 32'd0, 1'b1, 32'h00003344);
        p0_op(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 1'b1, 32'h00001122);

        p0_op(1'b1, 2'd1, 1'b0, NBYTES - 1, 32'hABCD, 1'b0, 32'd0);
        p0_op(1'b0, 2'd0, 1'b0, NBYTES - 1, 32'd0, 1'b1, 32'h000000CD);
        p0_op(1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b1, 32'h000000AB);
        p0_op(1'b0, 2'd1, 1'b0, NBYTES - 1, 32'd0, 1'b1, 32'h0000ABCD);
        idle(1);

        // Same-word P0 store and P1 read: P1 must see the previous contents.
        step(1'b1, 1'b1, 2'd0, 1'b0, 32'h8, 32'h55, 1'b1, 32'h8, 1'b0, 32'd0, acc);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b0, 32'd0, acc);
        idle(1);

        // Reset while the second half of a misaligned store is pending.
        p0_op(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 1'b0, 32'd0);
        p0_valid = 1'b0;
        rst_n = 1'b0;
        pend.delete();
        e = q0.pop_back();
        exp_ready = 1'b1;
        #1;
        chk("splitrst_p0_ready", 32'(p0_ready), 32'd1);
        chk("splitrst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        @(negedge clk);
        chk("splitrst_p0_rvalid2", 32'(p0_rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        p0_op(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 1'b1, 32'h0000F00D);
        p0_op(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, 1'b0, 32'd0);
        p0_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0);

        // Random mixed traffic on both ports inside the prefilled window.
        have = 1'b0;
        rv = 1'b0; rwe = 1'b0; rsx = 1'b0; rsz = 2'd0; ra = 32'd0; rwd = 32'd0;
        for (int i = 0; i < 600; i++) begin
            if (!have) begin
                rv  = ($urandom_range(0, 9) < 8);
                rwe = 1'($urandom_range(0, 1));
                rsz = 2'($urandom_range(0, 3));
                rsx = 1'($urandom_range(0, 1));
                i0  = $urandom_range(0, 19);
                if (i0 >= 16) i0++;
                ra  = ($urandom() & 32'hFFFF_F000) | (win(i0) * 4) | 32'($urandom_range(0, 3));
                rwd = $urandom();
                have = rv;
            end
            pe = 1'($urandom_range(0, 1));
            pa = ($urandom() & 32'hFFFF_F000) | (win($urandom_range(0, 20)) * 4)
                 | 32'($urandom_range(0, 3));
            step(rv, rwe, rsz, rsx, ra, rwd, pe, pa, 1'b0, 32'd0, acc);
            if (acc) have = 1'b0;
        end
        idle(4);
        chk("p0_queue_drained", 32'(q0.size()), 32'd0);
        chk("p1_queue_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
